i2s_tdm_rx: RTL and testbench

//  Parametrised I2S/TDM receiver. All logic runs in the single system clock clk (196.608 MHz). bclk/lrck/datai are

---
 rtl/i2s_tdm_rx.sv | 255 +++++++++++++++++++++++++
 tb/tb_i2s_tdm_rx.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/i2s_tdm_rx.sv
// I2S/TDM receiver: oversamples bclk/lrck/datai in the clk domain, deserialises
// per-slot words and streams them out through a small valid/ready FIFO.
module i2s_tdm_rx #(
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned MAX_SLOTS   = 16,
  parameter int unsigned FIFO_DEPTH  = 4,
  parameter int unsigned SYNC_STAGES = 2,
  localparam int unsigned SLOT_W     = $clog2(MAX_SLOTS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              bclk,
  input  logic              lrck,
  input  logic              datai,
  input  logic              cfg_enable,
  input  logic [4:0]        cfg_tdm_num,
  input  logic [5:0]        cfg_word_width,
  input  logic              cfg_lrck_polarity,
  input  logic              cfg_lrck_delay,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DATA_W-1:0] m_data,
  output logic [SLOT_W-1:0] m_slot,
  output logic              m_last,
  output logic              overflow,
  output logic              frame_err,
  output logic [31:0]       frame_count
);

  localparam int unsigned TDM_W = 5;
  localparam int unsigned WW_W  = 6;
  localparam int unsigned AW    = $clog2(FIFO_DEPTH);
  localparam int unsigned ENT_W = DATA_W + SLOT_W + 1;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_HUNT = 2'd1;
  localparam logic [1:0] ST_RUN  = 2'd2;
  localparam logic [1:0] ST_WAIT = 2'd3;

  // Pin synchronisers and bclk rising-edge strobe
  logic [SYNC_STAGES-1:0] bclk_sync, lrck_sync, data_sync;
  logic                   bclk_q, lrck_last;
  logic                   bclk_s, lrck_s, data_s, strobe, fs;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bclk_sync <= '0;
      lrck_sync <= '0;
      data_sync <= '0;
      bclk_q    <= 1'b0;
      lrck_last <= 1'b0;
    end else begin
      bclk_sync <= {bclk_sync[SYNC_STAGES-2:0], bclk};
      lrck_sync <= {lrck_sync[SYNC_STAGES-2:0], lrck};
      data_sync <= {data_sync[SYNC_STAGES-2:0], datai};
      bclk_q    <= bclk_s;
      if (strobe) lrck_last <= lrck_s;
    end
  end

  assign bclk_s = bclk_sync[SYNC_STAGES-1];
  assign lrck_s = lrck_sync[SYNC_STAGES-1];
  assign data_s = data_sync[SYNC_STAGES-1];
  assign strobe = bclk_s & ~bclk_q;
  // lrck is compared strobe-to-strobe, so the edge is seen on the first strobe after it
  assign fs     = strobe & (cfg_lrck_polarity ? (lrck_s & ~lrck_last) : (~lrck_s & lrck_last));

  // Configuration clamping applied when the shadow copy is taken
  logic [TDM_W-1:0] tdm_clamp;
  logic [WW_W-1:0]  ww_clamp;

  always_comb begin
    tdm_clamp = cfg_tdm_num;
    if (cfg_tdm_num == '0)                      tdm_clamp = TDM_W'(1);
    else if (cfg_tdm_num > TDM_W'(MAX_SLOTS))   tdm_clamp = TDM_W'(MAX_SLOTS);
    ww_clamp = cfg_word_width;
    if (cfg_word_width == '0 || cfg_word_width > WW_W'(DATA_W)) ww_clamp = WW_W'(DATA_W);
  end

  // Deserialiser state
  logic [1:0]        state, state_n;
  logic [WW_W-1:0]   bit_cnt, bit_n;
  logic [SLOT_W-1:0] slot_cnt, slot_n;
  logic [TDM_W-1:0]  tdm_sh, tdm_n;
  logic [WW_W-1:0]   ww_sh, ww_n;
  logic [DATA_W-1:0] shift_q, shift_n, shifted;
  logic              word_done, slot_last, restart;
  logic              push_c, push_last_c, err_c;
  logic [DATA_W-1:0] push_data_c;
  logic [SLOT_W-1:0] push_slot_c;

  assign shifted   = (bit_cnt == '0) ? DATA_W'(data_s) : {shift_q[DATA_W-2:0], data_s};
  assign word_done = (bit_cnt == ww_sh - WW_W'(1));
  assign slot_last = (TDM_W'(slot_cnt) == tdm_sh - TDM_W'(1));

  always_comb begin
    state_n     = state;
    bit_n       = bit_cnt;
    slot_n      = slot_cnt;
    tdm_n       = tdm_sh;
    ww_n        = ww_sh;
    shift_n     = shift_q;
    push_c      = 1'b0;
    push_data_c = shifted;
    push_slot_c = slot_cnt;
    push_last_c = 1'b0;
    err_c       = 1'b0;
    restart     = 1'b0;

    if (!cfg_enable) begin
      state_n = ST_IDLE;
      bit_n   = '0;
      slot_n  = '0;
    end else begin
      unique case (state)
        ST_IDLE: state_n = ST_HUNT;
        ST_HUNT: restart = fs;
        ST_RUN: begin
          if (strobe) begin
            if (word_done) begin
              push_c      = 1'b1;
              push_data_c = shifted;
              push_slot_c = slot_cnt;
              push_last_c = slot_last;
            end
            // A completed word is pushed before a coincident frame start restarts the frame
            if (fs) begin
              restart = 1'b1;
              err_c   = word_done ? !slot_last : (bit_cnt != '0 || slot_cnt != '0);
            end else if (word_done) begin
              shift_n = shifted;
              bit_n   = '0;
              if (slot_last) state_n = ST_WAIT;
              else           slot_n  = slot_cnt + SLOT_W'(1);
            end else begin
              shift_n = shifted;
              bit_n   = bit_cnt + WW_W'(1);
            end
          end
        end
        ST_WAIT: restart = fs;
        default: state_n = ST_IDLE;
      endcase
    end

    if (restart) begin
      tdm_n   = tdm_clamp;
      ww_n    = ww_clamp;
      state_n = ST_RUN;
      slot_n  = '0;
      bit_n   = '0;
      // Without the one-bclk delay the frame-start strobe already carries the MSB
      if (!cfg_lrck_delay) begin
        shift_n = DATA_W'(data_s);
        if (ww_clamp == WW_W'(1)) begin
          if (!push_c) begin
            push_c      = 1'b1;
            push_data_c = DATA_W'(data_s);
            push_slot_c = '0;
            push_last_c = (tdm_clamp == TDM_W'(1));
            if (tdm_clamp == TDM_W'(1)) state_n = ST_WAIT;
            else                        slot_n  = SLOT_W'(1);
          end
        end else begin
          bit_n = WW_W'(1);
        end
      end
    end
  end

  logic              push_req, push_last;
  logic [DATA_W-1:0] push_data;
  logic [SLOT_W-1:0] push_slot;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      bit_cnt   <= '0;
      slot_cnt  <= '0;
      tdm_sh    <= TDM_W'(1);
      ww_sh     <= WW_W'(DATA_W);
      shift_q   <= '0;
      push_req  <= 1'b0;
      push_data <= '0;
      push_slot <= '0;
      push_last <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      state     <= state_n;
      bit_cnt   <= bit_n;
      slot_cnt  <= slot_n;
      tdm_sh    <= tdm_n;
      ww_sh     <= ww_n;
      shift_q   <= shift_n;
      push_req  <= push_c;
      frame_err <= err_c;
      if (push_c) begin
        push_data <= push_data_c;
        push_slot <= push_slot_c;
        push_last <= push_last_c;
      end
    end
  end

  // Output FIFO with a registered head entry
  logic [ENT_W-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr, rd_n;
  logic [AW:0]      count, count_n;
  logic             pop, full, push_ok;
  logic [ENT_W-1:0] entry_in, head_n;

  assign pop      = m_valid & m_ready;
  assign full     = (count == (AW+1)'(FIFO_DEPTH));
  assign push_ok  = push_req & (~full | pop);
  assign entry_in = {push_data, push_slot, push_last};
  assign rd_n     = pop ? rd_ptr + AW'(1) : rd_ptr;

  always_comb begin
    unique case ({push_ok, pop})
      2'b10:   count_n = count + (AW+1)'(1);
      2'b01:   count_n = count - (AW+1)'(1);
      default: count_n = count;
    endcase
    if (count_n == '0)                        head_n = {m_data, m_slot, m_last};
    else if (push_ok && (wr_ptr == rd_n))     head_n = entry_in;
    else                                      head_n = mem[rd_n];
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= entry_in;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      m_valid     <= 1'b0;
      m_data      <= '0;
      m_slot      <= '0;
      m_last      <= 1'b0;
      overflow    <= 1'b0;
      frame_count <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      rd_ptr   <= rd_n;
      count    <= count_n;
      m_valid  <= (count_n != '0);
      {m_data, m_slot, m_last} <= head_n;
      overflow <= push_req & ~push_ok;
      if (push_req && push_last) frame_count <= frame_count + 32'd1;
    end
  end

endmodule

// File: tb/tb_i2s_tdm_rx.sv
// Directed bench for i2s_tdm_rx: bit-level I2S/TDM streams are built into
// arrays, played on the pins, and the collected output beats are checked.
module tb_i2s_tdm_rx;

  logic        clk = 1'b0;
  logic        rst_n, bclk, lrck, datai;
  logic        cfg_enable, cfg_lrck_polarity, cfg_lrck_delay;
  logic [4:0]  cfg_tdm_num;
  logic [5:0]  cfg_word_width;
  logic        m_valid, m_ready, m_last, overflow, frame_err;
  logic [31:0] m_data, frame_count;
  logic [3:0]  m_slot;

  i2s_tdm_rx dut (
    .clk(clk), .rst_n(rst_n), .bclk(bclk), .lrck(lrck), .datai(datai),
    .cfg_enable(cfg_enable), .cfg_tdm_num(cfg_tdm_num), .cfg_word_width(cfg_word_width),
    .cfg_lrck_polarity(cfg_lrck_polarity), .cfg_lrck_delay(cfg_lrck_delay),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_slot(m_slot),
    .m_last(m_last), .overflow(overflow), .frame_err(frame_err), .frame_count(frame_count)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  logic [36:0] beats[$];
  int          ovf_n = 0;
  int          err_n = 0;

  // Beat collector: a beat is taken on the edge following valid&ready
  always @(negedge clk) begin
    if (m_valid && m_ready) beats.push_back({m_last, m_slot, m_data});
    if (overflow)  ovf_n++;
    if (frame_err) err_n++;
  end

  logic        lr_s [0:255];
  logic        d_s  [0:255];
  logic [31:0] wbuf [0:15];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [36:0] beat_at(input int i);
    if (i < beats.size()) return beats[i];
    return 'x;
  endfunction

  function automatic logic [36:0] mk(input logic last, input logic [3:0] slot, input logic [31:0] d);
    return {last, slot, d};
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clear_stream(input logic pol);
    for (int i = 0; i < 256; i++) begin
      lr_s[i] = ~pol;
      d_s[i]  = 1'b0;
    end
  endtask

  task automatic fill_frame(input int base, input int flen, input bit pulse, input int ns,
                            input int slen, input int ww, input int dly, input logic pol,
                            input bit slack_ones);
    for (int p = 0; p < flen; p++)
      lr_s[base+p] = (pulse ? (p == 0) : (p < flen/2)) ? pol : ~pol;
    for (int s = 0; s < ns; s++) begin
      for (int b = 0; b < ww; b++)   d_s[base+dly+s*slen+b] = wbuf[s][ww-1-b];
      if (slack_ones)
        for (int b = ww; b < slen; b++) d_s[base+dly+s*slen+b] = 1'b1;
    end
  endtask

  // One bclk period = 8 clk: low 4, high 4; pins change while bclk falls
  task automatic play(input int from, input int to);
    for (int i = from; i < to; i++) begin
      bclk  = 1'b0;
      lrck  = lr_s[i];
      datai = d_s[i];
      tick(4);
      bclk  = 1'b1;
      tick(4);
    end
  endtask

  int b0, o0, e0;

  initial begin
    rst_n = 1'b0; bclk = 1'b0; lrck = 1'b1; datai = 1'b0; m_ready = 1'b1;
    cfg_enable = 1'b0; cfg_tdm_num = 5'd2; cfg_word_width = 6'd32;
    cfg_lrck_polarity = 1'b0; cfg_lrck_delay = 1'b1;
    tick(3);
    check("rst_valid", 64'(m_valid), 64'd0);
    check("rst_data", 64'(m_data), 64'd0);
    check("rst_slot", 64'(m_slot), 64'd0);
    check("rst_last", 64'(m_last), 64'd0);
    check("rst_ovf", 64'(overflow), 64'd0);
    check("rst_ferr", 64'(frame_err), 64'd0);
    check("rst_fcnt", 64'(frame_count), 64'd0);
    rst_n = 1'b1;
    cfg_enable = 1'b1;
    tick(4);

    // Stereo I2S, 32-bit words, one-bclk delay
    b0 = beats.size(); e0 = err_n;
    wbuf[0] = 32'h12345678; wbuf[1] = 32'h9ABCDEF0;
    clear_stream(1'b0);
    fill_frame(4, 64, 1'b0, 2, 32, 32, 1, 1'b0, 1'b0);
    play(0, 72);
    tick(8);
    check("i2s_nbeats", 64'(beats.size() - b0), 64'd2);
    check("i2s_beat0", 64'(beat_at(b0)),   64'(mk(1'b0, 4'd0, 32'h12345678)));
    check("i2s_beat1", 64'(beat_at(b0+1)), 64'(mk(1'b1, 4'd1, 32'h9ABCDEF0)));
    check("i2s_fcnt", 64'(frame_count), 64'd1);
    check("i2s_ferr", 64'(err_n - e0), 64'd0);

    // TDM8, 16-bit slots, rising 1-bclk fsync, no delay
    cfg_tdm_num = 5'd8; cfg_word_width = 6'd16; cfg_lrck_polarity = 1'b1; cfg_lrck_delay = 1'b0;
    b0 = beats.size();
    for (int k = 0; k < 8; k++) wbuf[k] = 32'h1000 + 32'(k);
    clear_stream(1'b1);
    fill_frame(4, 128, 1'b1, 8, 16, 16, 0, 1'b1, 1'b0);
    play(0, 136);
    tick(8);
    check("tdm_nbeats", 64'(beats.size() - b0), 64'd8);
    for (int k = 0; k < 8; k++)
      check("tdm_beat", 64'(beat_at(b0+k)), 64'(mk(k == 7, 4'(k), 32'h1000 + 32'(k))));
    check("tdm_fcnt", 64'(frame_count), 64'd2);

    // Mono, 20-bit word in 32-bit frame; slack bits driven to 1
    cfg_tdm_num = 5'd1; cfg_word_width = 6'd20; cfg_lrck_polarity = 1'b0; cfg_lrck_delay = 1'b1;
    b0 = beats.size(); e0 = err_n;
    clear_stream(1'b0);
    wbuf[0] = 32'h000ABCDE;
    fill_frame(4, 32, 1'b0, 1, 32, 20, 1, 1'b0, 1'b1);
    wbuf[0] = 32'h00054321;
    fill_frame(36, 32, 1'b0, 1, 32, 20, 1, 1'b0, 1'b1);
    play(0, 72);
    tick(8);
    check("ww20_nbeats", 64'(beats.size() - b0), 64'd2);
    check("ww20_beat0", 64'(beat_at(b0)),   64'(mk(1'b1, 4'd0, 32'h000ABCDE)));
    check("ww20_beat1", 64'(beat_at(b0+1)), 64'(mk(1'b1, 4'd0, 32'h00054321)));
    check("ww20_ferr", 64'(err_n - e0), 64'd0);

    // Back-pressure: three back-to-back stereo frames into a 4-deep FIFO
    cfg_tdm_num = 5'd2; cfg_word_width = 6'd32;
    m_ready = 1'b0;
    b0 = beats.size(); o0 = ovf_n; e0 = err_n;
    clear_stream(1'b0);
    wbuf[0] = 32'h11110000; wbuf[1] = 32'h11110001;
    fill_frame(4, 64, 1'b0, 2, 32, 32, 1, 1'b0, 1'b0);
    wbuf[0] = 32'h22220000; wbuf[1] = 32'h22220001;
    fill_frame(68, 64, 1'b0, 2, 32, 32, 1, 1'b0, 1'b0);
    wbuf[0] = 32'h33330000; wbuf[1] = 32'h33330001;
    fill_frame(132, 64, 1'b0, 2, 32, 32, 1, 1'b0, 1'b0);
    play(0, 200);
    tick(8);
    check("bp_ovf", 64'(ovf_n - o0), 64'd2);
    check("bp_ferr", 64'(err_n - e0), 64'd0);
    check("bp_valid", 64'(m_valid), 64'd1);
    check("bp_head", 64'({m_last, m_slot, m_data}), 64'(mk(1'b0, 4'd0, 32'h11110000)));
    m_ready = 1'b1;
    tick(12);
    check("bp_nbeats", 64'(beats.size() - b0), 64'd4);
    check("bp_beat0", 64'(beat_at(b0)),   64'(mk(1'b0, 4'd0, 32'h11110000)));
    check("bp_beat1", 64'(beat_at(b0+1)), 64'(mk(1'b1, 4'd1, 32'h11110001)));
    check("bp_beat2", 64'(beat_at(b0+2)), 64'(mk(1'b0, 4'd0, 32'h22220000)));
    check("bp_beat3", 64'(beat_at(b0+3)), 64'(mk(1'b1, 4'd1, 32'h22220001)));
    check("bp_empty", 64'(m_valid), 64'd0);

    // Early frame start 40 bits into a stereo frame
    b0 = beats.size(); e0 = err_n;
    clear_stream(1'b0);
    wbuf[0] = 32'hA5A5A5A5; wbuf[1] = 32'h5A5A5A5A;
    fill_frame(4, 64, 1'b0, 2, 32, 32, 1, 1'b0, 1'b0);
    wbuf[0] = 32'hC0DEC0DE; wbuf[1] = 32'hFEEDFACE;
    fill_frame(44, 64, 1'b0, 2, 32, 32, 1, 1'b0, 1'b0);
    play(0, 112);
    tick(8);
    check("ferr_pulse", 64'(err_n - e0), 64'd1);
    check("ferr_nbeats", 64'(beats.size() - b0), 64'd3);
    check("ferr_beat0", 64'(beat_at(b0)),   64'(mk(1'b0, 4'd0, 32'hA5A5A5A5)));
    check("ferr_beat1", 64'(beat_at(b0+1)), 64'(mk(1'b0, 4'd0, 32'hC0DEC0DE)));
    check("ferr_beat2", 64'(beat_at(b0+2)), 64'(mk(1'b1, 4'd1, 32'hFEEDFACE)));

    // Reset in the middle of a word
    b0 = beats.size();
    clear_stream(1'b0);
    wbuf[0] = 32'hCAFEF00D; wbuf[1] = 32'h0BADBEEF;
    fill_frame(4, 64, 1'b0, 2, 32, 32, 1, 1'b0, 1'b0);
    play(0, 24);
    rst_n = 1'b0;
    #1;
    check("mid_rst_fcnt", 64'(frame_count), 64'd0);
    check("mid_rst_valid", 64'(m_valid), 64'd0);
    check("mid_rst_data", 64'(m_data), 64'd0);
    tick(2);
    rst_n = 1'b1;
    play(24, 72);
    tick(8);
    check("post_rst_nobeat", 64'(beats.size() - b0), 64'd0);
    play(0, 72);
    tick(8);
    check("post_rst_nbeats", 64'(beats.size() - b0), 64'd2);
    check("post_rst_beat0", 64'(beat_at(b0)),   64'(mk(1'b0, 4'd0, 32'hCAFEF00D)));
    check("post_rst_beat1", 64'(beat_at(b0+1)), 64'(mk(1'b1, 4'd1, 32'h0BADBEEF)));
    check("post_rst_fcnt", 64'(frame_count), 64'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
